// File: rtl/axi_rd_responder.sv
// Memory-side read responder: accepts one 2-D read request, streams word reads
// through a 1-cycle memory and returns the beats via a 2-entry skid FIFO.
module axi_rd_responder #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        lsu_axi_arid,
  input  logic [ADDR_W-1:0] lsu_axi_araddr,
  input  logic [7:0]        lsu_axi_arlen,
  input  logic [2:0]        lsu_axi_arsize,
  input  logic [1:0]        lsu_axi_arburst,
  input  logic [2:0]        lsu_axi_arstr,
  input  logic [7:0]        lsu_axi_arnum,
  input  logic              lsu_axi_arvld,
  input  logic              lsu_axi_rrdy,
  output logic              axi_lsu_arrdy,
  output logic [7:0]        axi_lsu_rid,
  output logic [DATA_W-1:0] axi_lsu_rdata,
  output logic [1:0]        axi_lsu_rresp,
  output logic              axi_lsu_rlast,
  output logic              axi_lsu_rvld,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state;
  logic              arrdy_q;
  logic [7:0]        id_q, len_q, num_q, beat_cnt, row_cnt;
  logic [2:0]        str_q;
  logic              incr_q, err_q;
  logic [ADDR_W-1:0] addr_q, row_base;

  logic              vld_p1, err_p1, last_p1;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_err  [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              issue, row_end, last_beat;
  logic [ADDR_W-1:0] row_base_nxt;
  logic              pop, pop_fifo, push;
  logic [DATA_W-1:0] push_data;

  // Credit: beats held in the FIFO plus the one whose data is arriving must leave room.
  assign issue        = (state == ISSUE) && ((int'(count) + int'(vld_p1)) < FIFO_DEPTH);
  assign row_end      = (beat_cnt == len_q);
  assign last_beat    = row_end && (row_cnt == num_q);
  assign row_base_nxt = row_base + ADDR_W'(len_q) + ADDR_W'(1) + ADDR_W'(str_q);

  assign mem_rd_en     = issue && !err_q;
  assign mem_rd_addr   = addr_q;
  assign axi_lsu_arrdy = arrdy_q;
  assign axi_lsu_rid   = id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      arrdy_q  <= 1'b0;
      id_q     <= '0;
      len_q    <= '0;
      num_q    <= '0;
      str_q    <= '0;
      incr_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      row_base <= '0;
      beat_cnt <= '0;
      row_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!arrdy_q) begin
            arrdy_q <= 1'b1;
          end else if (lsu_axi_arvld) begin
            arrdy_q  <= 1'b0;
            id_q     <= lsu_axi_arid;
            len_q    <= lsu_axi_arlen;
            num_q    <= lsu_axi_arnum;
            str_q    <= lsu_axi_arstr;
            incr_q   <= (lsu_axi_arburst == 2'b01);
            err_q    <= (lsu_axi_arsize != 3'd3) || lsu_axi_arburst[1];
            addr_q   <= lsu_axi_araddr;
            row_base <= lsu_axi_araddr;
            beat_cnt <= '0;
            row_cnt  <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (row_end) begin
              row_base <= row_base_nxt;
              addr_q   <= row_base_nxt;
              beat_cnt <= '0;
              row_cnt  <= row_cnt + 8'd1;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              if (incr_q) addr_q <= addr_q + ADDR_W'(1);
            end
            if (last_beat) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((count == '0) && !vld_p1) begin
            state   <= IDLE;
            arrdy_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: memory data for the beat issued last cycle is on mem_rd_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= issue;
  end

  always_ff @(posedge clk) begin
    err_p1  <= err_q;
    last_p1 <= last_beat;
  end

  // The p1 beat falls straight through to the output when the FIFO is empty.
  assign pop       = axi_lsu_rvld && lsu_axi_rrdy;
  assign pop_fifo  = pop && (count != '0);
  assign push      = vld_p1 && !(pop && (count == '0));
  assign push_data = err_p1 ? '0 : mem_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop_fifo);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_err[wr_ptr]  <= err_p1;
      fifo_last[wr_ptr] <= last_p1;
    end
  end

  always_comb begin
    axi_lsu_rvld  = 1'b0;
    axi_lsu_rdata = '0;
    axi_lsu_rresp = 2'b00;
    axi_lsu_rlast = 1'b0;
    if (count != '0) begin
      axi_lsu_rvld  = 1'b1;
      axi_lsu_rdata = fifo_data[rd_ptr];
      axi_lsu_rresp = fifo_err[rd_ptr] ? 2'b10 : 2'b00;
      axi_lsu_rlast = fifo_last[rd_ptr];
    end else if (vld_p1) begin
      axi_lsu_rvld  = 1'b1;
      axi_lsu_rdata = push_data;
      axi_lsu_rresp = err_p1 ? 2'b10 : 2'b00;
      axi_lsu_rlast = last_p1;
    end
  end

endmodule
